rnn_mem_arbiter: RTL and testbench

//  Shares the single RNN memory port (mce/msel/maddr/mdata_w/mdata_r) between two requesters.

---
 rtl/rnn_mem_arbiter.sv | 117 +++++++++++
 tb/tb_rnn_mem_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rnn_mem_arbiter.sv
// Two-port arbiter for the single RNN memory port.
// Fixed priority to A, with burst locks and a B starvation guard.
module rnn_mem_arbiter #(
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_req,
  input  logic        a_lock,
  input  logic [2:0]  a_msel,
  input  logic [16:0] a_addr,
  input  logic [19:0] a_wdata,
  output logic        a_gnt,
  output logic        a_rvalid,
  output logic [19:0] a_rdata,
  input  logic        b_req,
  input  logic        b_lock,
  input  logic [2:0]  b_msel,
  input  logic [16:0] b_addr,
  input  logic [19:0] b_wdata,
  output logic        b_gnt,
  output logic        b_rvalid,
  output logic [19:0] b_rdata,
  output logic        mce,
  output logic [2:0]  msel,
  output logic [16:0] maddr,
  output logic [19:0] mdata_w,
  input  logic [19:0] mdata_r
);

  typedef enum logic [1:0] {
    ARB,
    LOCK_A,
    LOCK_B
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] wait_cnt;
  logic             force_b;
  logic             tag_b;

  always_ff @(posedge clk) begin
    if (reset) state <= ARB;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ARB: begin
        if (a_gnt && a_lock)      state_nxt = LOCK_A;
        else if (b_gnt && b_lock) state_nxt = LOCK_B;
      end
      LOCK_A:  if (!a_lock) state_nxt = ARB;
      LOCK_B:  if (!b_lock) state_nxt = ARB;
      default: state_nxt = ARB;
    endcase
  end

  assign force_b = b_req && (wait_cnt == CNT_W'(MAX_WAIT));

  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (!reset) begin
      unique case (state)
        ARB: begin
          a_gnt = a_req && !force_b;
          b_gnt = b_req && (!a_req || force_b);
        end
        LOCK_A:  a_gnt = a_req;
        LOCK_B:  b_gnt = b_req;
        default: ;
      endcase
    end
  end

  // Counts while locked too, so B is first in line once ARB resumes
  always_ff @(posedge clk) begin
    if (reset || b_gnt || !b_req)
      wait_cnt <= '0;
    else if (wait_cnt != CNT_W'(MAX_WAIT))
      wait_cnt <= wait_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mce      <= 1'b0;
      msel     <= '0;
      maddr    <= '0;
      mdata_w  <= '0;
      tag_b    <= 1'b0;
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
    end else begin
      mce      <= a_gnt || b_gnt;
      tag_b    <= b_gnt;
      a_rvalid <= mce && !tag_b;
      b_rvalid <= mce && tag_b;
      if (b_gnt) begin
        msel    <= b_msel;
        maddr   <= b_addr;
        mdata_w <= b_wdata;
      end else if (a_gnt) begin
        msel    <= a_msel;
        maddr   <= a_addr;
        mdata_w <= a_wdata;
      end
    end
  end

  assign a_rdata = mdata_r;
  assign b_rdata = mdata_r;

endmodule

// File: tb/tb_rnn_mem_arbiter.sv
// Scoreboard bench for rnn_mem_arbiter.
// Reference model predicts grants; a monitor checks the memory pipeline.
module tb_rnn_mem_arbiter;

  localparam int MAX_WAIT = 15;
  localparam logic [19:0] KEY = 20'h5A5A5;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_req, a_lock, b_req, b_lock;
  logic [2:0]  a_msel, b_msel;
  logic [16:0] a_addr, b_addr;
  logic [19:0] a_wdata, b_wdata;
  logic        a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [19:0] a_rdata, b_rdata;
  logic        mce;
  logic [2:0]  msel;
  logic [16:0] maddr;
  logic [19:0] mdata_w, mdata_r;

  rnn_mem_arbiter #(.MAX_WAIT(MAX_WAIT), .CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_lock(a_lock), .a_msel(a_msel),
    .a_addr(a_addr), .a_wdata(a_wdata), .a_gnt(a_gnt),
    .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_lock(b_lock), .b_msel(b_msel),
    .b_addr(b_addr), .b_wdata(b_wdata), .b_gnt(b_gnt),
    .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .mce(mce), .msel(msel), .maddr(maddr),
    .mdata_w(mdata_w), .mdata_r(mdata_r)
  );

  always #5 clk = ~clk;

  // Memory stub: read data is a tag of the address presented last cycle
  always @(posedge clk) mdata_r <= {msel, maddr} ^ KEY;

  typedef struct {
    int          cyc;
    bit          en;
    logic [2:0]  sel;
    logic [16:0] addr;
    logic [19:0] wd;
  } mexp_t;

  typedef struct {
    int          cyc;
    bit          av;
    bit          bv;
    logic [19:0] rd;
  } rexp_t;

  mexp_t mq[$];
  rexp_t rq[$];

  int cyc = 0;
  int checks = 0;
  int passed = 0;

  // Model state: who holds the lock (0 none, 1 A, 2 B) and B's wait time
  int owner = 0;
  int waited = 0;
  logic [2:0]  h_sel = '0;
  logic [16:0] h_addr = '0;
  logic [19:0] h_wd = '0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp)
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    else
      passed++;
  endtask

  task automatic step();
    bit ga, gb;
    mexp_t m;
    rexp_t r;
    #1;
    ga = 0;
    gb = 0;
    if (!reset) begin
      if (owner == 1)                        ga = a_req;
      else if (owner == 2)                   gb = b_req;
      else if (b_req && waited >= MAX_WAIT)  gb = 1;
      else if (a_req)                        ga = 1;
      else if (b_req)                        gb = 1;
    end
    check("a_gnt", 32'(a_gnt), 32'(ga));
    check("b_gnt", 32'(b_gnt), 32'(gb));
    if (reset) begin
      h_sel = '0; h_addr = '0; h_wd = '0;
    end else if (ga) begin
      h_sel = a_msel; h_addr = a_addr; h_wd = a_wdata;
    end else if (gb) begin
      h_sel = b_msel; h_addr = b_addr; h_wd = b_wdata;
    end
    m = '{cyc + 1, ga | gb, h_sel, h_addr, h_wd};
    mq.push_back(m);
    r = '{cyc + 2, ga, gb, {h_sel, h_addr} ^ KEY};
    rq.push_back(r);
    if (reset) begin
      owner = 0;
      waited = 0;
      foreach (rq[i])
        if (rq[i].cyc == cyc + 1) begin
          rq[i].av = 0;
          rq[i].bv = 0;
        end
    end else begin
      if (owner == 1 && !a_lock)      owner = 0;
      else if (owner == 2 && !b_lock) owner = 0;
      else if (owner == 0 && ga && a_lock) owner = 1;
      else if (owner == 0 && gb && b_lock) owner = 2;
      if (gb || !b_req)             waited = 0;
      else if (waited < MAX_WAIT)   waited++;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic drive(
    input bit ar, input bit al, input logic [2:0] am,
    input logic [16:0] aa, input logic [19:0] aw,
    input bit br, input bit bl, input logic [2:0] bm,
    input logic [16:0] ba, input logic [19:0] bw
  );
    a_req = ar; a_lock = al; a_msel = am; a_addr = aa; a_wdata = aw;
    b_req = br; b_lock = bl; b_msel = bm; b_addr = ba; b_wdata = bw;
    step();
  endtask

  function automatic logic [2:0] r3();
    return 3'($urandom);
  endfunction
  function automatic logic [16:0] r17();
    return 17'($urandom);
  endfunction
  function automatic logic [19:0] r20();
    return 20'($urandom);
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      drive(0, 0, r3(), r17(), r20(), 0, 0, r3(), r17(), r20());
  endtask

  // Monitor: pops the expectation for this cycle and compares outputs
  initial begin
    forever begin
      @(negedge clk);
      while (mq.size() > 0 && mq[0].cyc < cyc) void'(mq.pop_front());
      while (rq.size() > 0 && rq[0].cyc < cyc) void'(rq.pop_front());
      if (mq.size() > 0 && mq[0].cyc == cyc) begin
        mexp_t m;
        m = mq.pop_front();
        check("mce", 32'(mce), 32'(m.en));
        check("msel", 32'(msel), 32'(m.sel));
        check("maddr", 32'(maddr), 32'(m.addr));
        check("mdata_w", 32'(mdata_w), 32'(m.wd));
      end
      if (rq.size() > 0 && rq[0].cyc == cyc) begin
        rexp_t r;
        r = rq.pop_front();
        check("a_rvalid", 32'(a_rvalid), 32'(r.av));
        check("b_rvalid", 32'(b_rvalid), 32'(r.bv));
        if (r.av) check("a_rdata", 32'(a_rdata), 32'(r.rd));
        if (r.bv) check("b_rdata", 32'(b_rdata), 32'(r.rd));
      end
    end
  end

  initial begin
    reset = 1'b1;
    a_req = 0; a_lock = 0; a_msel = '0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_lock = 0; b_msel = '0; b_addr = '0; b_wdata = '0;
    @(negedge clk);
    step();
    step();
    reset = 1'b0;
    idle(2);

    // A-only stream
    for (int i = 0; i < 64; i++)
      drive(1, 0, r3(), 17'(i), r20(), 0, 0, r3(), r17(), r20());
    idle(3);

    // A and B contend, B starves until forced
    for (int i = 0; i < 40; i++)
      drive(1, 0, r3(), r17(), r20(), 1, 0, r3(), r17(), r20());
    idle(2);

    // A locks with B waiting, then releases
    for (int i = 0; i < 40; i++)
      drive(1, 1, r3(), r17(), r20(), 1, 0, r3(), r17(), r20());
    drive(1, 0, r3(), r17(), r20(), 1, 0, r3(), r17(), r20());
    for (int i = 0; i < 4; i++)
      drive(1, 0, r3(), r17(), r20(), 1, 0, r3(), r17(), r20());
    idle(2);

    // B write burst, A waiting
    drive(0, 0, r3(), r17(), r20(), 1, 1, 3'b101, 17'h100, r20());
    for (int i = 1; i < 8; i++)
      drive(1, 0, r3(), r17(), r20(), 1, 1, 3'b101, 17'(32'h100 + i), r20());
    drive(1, 0, r3(), r17(), r20(), 1, 0, 3'b101, 17'h108, r20());
    for (int i = 0; i < 3; i++)
      drive(1, 0, r3(), r17(), r20(), 0, 0, r3(), r17(), r20());
    idle(2);

    // Reset right after an A read is accepted
    drive(1, 0, 3'b001, 17'h0AB, r20(), 0, 0, r3(), r17(), r20());
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    drive(0, 0, r3(), r17(), r20(), 1, 0, r3(), r17(), r20());
    idle(3);

    // Lock held idle
    drive(1, 1, r3(), r17(), r20(), 0, 0, r3(), r17(), r20());
    for (int i = 0; i < 3; i++)
      drive(0, 1, r3(), r17(), r20(), 1, 0, r3(), r17(), r20());
    drive(1, 0, r3(), r17(), r20(), 1, 0, r3(), r17(), r20());
    idle(2);

    // Random traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 199) == 0);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
            r3(), r17(), r20(),
            $urandom_range(0, 2) != 0, $urandom_range(0, 5) == 0,
            r3(), r17(), r20());
    end
    reset = 1'b0;
    idle(4);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
